// File: rtl/adder32_mw_seq.sv
// Multi-word add/subtract sequencer time-sharing one external 32-bit adder, LSW first.
// Latency: response valid WORDS cycles after the request handshake; one op per WORDS+2 cycles.
// Backpressure: result held in DONE until rsp_ready; requests accepted only in IDLE.

// Reference 32-bit full adder driven by the sequencer's add_* ports.
module FullAdder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] total;

    // Plain 33-bit addition; the top bit is the carry-out.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        sum   = total[31:0];
        cout  = total[32];
    end
endmodule

module adder32_mw_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [WORDS*32-1:0] req_a,
    input  logic [WORDS*32-1:0] req_b,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_cin,
    input  logic [31:0]         add_sum,
    input  logic                add_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDS*32-1:0] rsp_sum,
    output logic                rsp_carry,
    output logic                rsp_ovf
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic                     carry_reg;
    logic                     op_reg;
    logic [WORDS-1:0][31:0]   a_reg;
    logic [WORDS-1:0][31:0]   b_reg;   // B already inverted for subtract
    logic [WORDS-1:0][31:0]   sum_reg;
    logic                     ovf_last;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum_reg;

    // Signed overflow of the whole operation, judged on the most significant word.
    assign ovf_last = (a_reg[WORDS-1][31] == b_reg[WORDS-1][31]) &&
                      (add_sum[31] != a_reg[WORDS-1][31]);

    // Feed the shared adder only while running; idle it at zero otherwise.
    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = (idx == '0) ? op_reg : carry_reg;
        end
    end

    // Sequencer: latch operands, walk the words LSW first, hold the result for the client.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            op_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg  <= req_a;
                        b_reg  <= req_op ? ~req_b : req_b;
                        op_reg <= req_op;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= add_sum;
                    carry_reg    <= add_cout;
                    if (idx == LAST) begin
                        rsp_carry <= add_cout;
                        rsp_ovf   <= ovf_last;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder32_mw_seq.sv
// Self-checking bench for adder32_mw_seq: WORDS=4 and WORDS=1 instances, each on its own adder.
// Directed corner cases plus randomized operations against a plain-arithmetic reference model.
// Exercises response backpressure, pending requests and reset mid-operation.
module tb_adder32_mw_seq;
    logic clk;
    logic rst_n;

    // WORDS = 4 instance
    logic         req_valid, req_ready, req_op;
    logic [127:0] req_a, req_b;
    logic [31:0]  add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         rsp_valid, rsp_ready, rsp_carry, rsp_ovf;
    logic [127:0] rsp_sum;

    // WORDS = 1 instance
    logic         req_valid1, req_ready1, req_op1;
    logic [31:0]  req_a1, req_b1;
    logic [31:0]  add_a1, add_b1, add_sum1;
    logic         add_cin1, add_cout1;
    logic         rsp_valid1, rsp_ready1, rsp_carry1, rsp_ovf1;
    logic [31:0]  rsp_sum1;

    int checks = 0;
    int errors = 0;

    adder32_mw_seq #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
    );

    FullAdder32bit fa (
        .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
    );

    adder32_mw_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
        .req_a(req_a1), .req_b(req_b1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_sum(rsp_sum1), .rsp_carry(rsp_carry1), .rsp_ovf(rsp_ovf1)
    );

    FullAdder32bit fa1 (
        .a(add_a1), .b(add_b1), .cin(add_cin1), .sum(add_sum1), .cout(add_cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: W-bit two's-complement add/subtract from first principles.
    function automatic void model(input logic [127:0] a, input logic [127:0] b, input logic op,
                                  output logic [127:0] s, output logic c, output logic v);
        logic [128:0] t;
        if (!op) begin
            t = {1'b0, a} + {1'b0, b};
            s = t[127:0];
            c = t[128];
            v = (a[127] == b[127]) && (s[127] != a[127]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[127] != b[127]) && (s[127] != a[127]);
        end
    endfunction

    function automatic void model1(input logic [31:0] a, input logic [31:0] b, input logic op,
                                   output logic [31:0] s, output logic c, output logic v);
        logic [32:0] t;
        if (!op) begin
            t = {1'b0, a} + {1'b0, b};
            s = t[31:0];
            c = t[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One WORDS=4 operation: handshake, latency, result, hold stability, response handshake.
    // With pend set, a second request is left asserted after the accept edge.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic op,
                          input int hold, input logic pend,
                          input logic [127:0] pa, input logic [127:0] pb, input logic pop);
        int n;
        int lat;
        logic [127:0] es;
        logic ec, ev;
        model(a, b, op, es, ec, ev);
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (pend) begin
            req_valid = 1'b1; req_a = pa; req_b = pb; req_op = pop;
        end else begin
            req_valid = 1'b0; req_a = rnd128(); req_b = rnd128(); req_op = $urandom_range(0, 1);
        end
        chk("cin_first", {127'd0, add_cin}, {127'd0, op});
        chk("add_a_w0", {96'd0, add_a}, {96'd0, a[31:0]});
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1 && !rsp_valid) begin
                chk("add_b_w1", {96'd0, add_b}, {96'd0, op ? ~b[63:32] : b[63:32]});
            end
        end
        chk("latency", lat, 4);
        chk("sum", rsp_sum, es);
        chk("carry", {127'd0, rsp_carry}, {127'd0, ec});
        chk("ovf", {127'd0, rsp_ovf}, {127'd0, ev});
        chk("add_a_idle", {96'd0, add_a}, 128'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {127'd0, rsp_valid}, 128'd1);
            chk("hold_sum", rsp_sum, es);
            chk("hold_rdy", {127'd0, req_ready}, 128'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("valid_drop", {127'd0, rsp_valid}, 128'd0);
        chk("rdy_back", {127'd0, req_ready}, 128'd1);
    endtask

    task automatic run_op1(input logic [31:0] a, input logic [31:0] b, input logic op);
        int lat;
        logic [31:0] es;
        logic ec, ev;
        model1(a, b, op, es, ec, ev);
        @(negedge clk);
        req_valid1 = 1'b1; req_a1 = a; req_b1 = b; req_op1 = op;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0; req_a1 = $urandom; req_b1 = $urandom;
        chk("w1_cin", {127'd0, add_cin1}, {127'd0, op});
        lat = 0;
        while (!rsp_valid1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w1_latency", lat, 1);
        chk("w1_sum", {96'd0, rsp_sum1}, {96'd0, es});
        chk("w1_carry", {127'd0, rsp_carry1}, {127'd0, ec});
        chk("w1_ovf", {127'd0, rsp_ovf1}, {127'd0, ev});
        @(negedge clk);
        rsp_ready1 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready1 = 1'b0;
        chk("w1_valid_drop", {127'd0, rsp_valid1}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ones;
        logic [127:0] maxpos;
        ones = '1;
        maxpos = {1'b0, {127{1'b1}}};
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_op1 = 1'b0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b0;
        #23;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {127'd0, req_ready}, 128'd1);
        chk("rst_valid", {127'd0, rsp_valid}, 128'd0);
        chk("rst_sum", rsp_sum, 128'd0);
        chk("rst_carry", {127'd0, rsp_carry}, 128'd0);
        chk("rst_ovf", {127'd0, rsp_ovf}, 128'd0);
        chk("rst_add_a", {96'd0, add_a}, 128'd0);
        chk("rst_add_cin", {127'd0, add_cin}, 128'd0);

        // Directed corners
        run_op(ones, 128'd1, 1'b0, 2, 1'b0, '0, '0, 1'b0);
        run_op(128'd0, 128'd1, 1'b1, 1, 1'b0, '0, '0, 1'b0);
        run_op(maxpos, 128'd1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Backpressure with a second request waiting behind the response
        run_op(rnd128(), rnd128(), 1'b0, 5, 1'b1, 128'h1234, 128'h0FFF, 1'b1);
        run_op(128'h1234, 128'h0FFF, 1'b1, 0, 1'b0, '0, '0, 1'b0);

        // Reset in the middle of a run (idx == 2)
        @(negedge clk);
        req_valid = 1'b1; req_a = rnd128(); req_b = rnd128(); req_op = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {127'd0, rsp_valid}, 128'd0);
        chk("mid_rst_ready", {127'd0, req_ready}, 128'd1);
        chk("mid_rst_sum", rsp_sum, 128'd0);
        chk("mid_rst_add_a", {96'd0, add_a}, 128'd0);
        chk("mid_rst_add_b", {96'd0, add_b}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {127'd0, rsp_valid}, 128'd0);
        end
        rsp_ready = 1'b0;
        run_op(128'd5, 128'd3, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Randomized operations
        for (int k = 0; k < 30; k++) begin
            logic [127:0] ra, rb;
            ra = rnd128();
            rb = rnd128();
            if (k % 5 == 0) rb = ra;
            if (k % 7 == 0) ra = {ra[127] ^ 1'b1, ra[126:0]};
            run_op(ra, rb, 1'(k % 2 == 1 ? 1 : $urandom_range(0, 1)), $urandom_range(0, 3),
                   1'b0, '0, '0, 1'b0);
        end

        // WORDS = 1 instance
        run_op1(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op1(32'd0, 32'd1, 1'b1);
        run_op1(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_op1($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder32_mw_seq.md
Name: adder32_mw_seq

Overview:
- Multi-word add/subtract sequencer that time-shares one external 32-bit ripple adder (FullAdder32bit) to produce WORDS*32-bit results, one 32-bit word per cycle, LSW first.
- Chains the carry between words and forms subtraction as A + ~B + 1.
- Sits between a request/response client (valid/ready) and the combinational adder instance, which it drives through the add_* ports.

Parameters:
WORDS, 4, number of 32-bit words per operand (legal 1..16); operand width W = WORDS*32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept request
req_op  input  1  0 = add, 1 = subtract (A - B)
req_a  input  W  operand A
req_b  input  W  operand B
add_a  output  32  to adder A
add_b  output  32  to adder B
add_cin  output  1  to adder Cin
add_sum  input  32  from adder Sum (combinational, same cycle)
add_cout  input  1  from adder Cout
rsp_valid  output  1  result present
rsp_ready  input  1  client accepts result
rsp_sum  output  W  result
rsp_carry  output  1  final carry-out (for subtract: 1 = no borrow)
rsp_ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; idx, carry_reg, operand and result registers = 0.
  - req_ready = 1 once out of reset; rsp_valid = 0; rsp_sum = 0; rsp_carry = 0; rsp_ovf = 0; add_a = add_b = 0; add_cin = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch A, B_eff (= req_b if op = 0, ~req_b if op = 1), op; idx <= 0; go to RUN.
- RUN:
  - req_ready = 0.
  - add_a = A word[idx]; add_b = B_eff word[idx]; add_cin = (idx == 0) ? op : carry_reg.
  - Each cycle: result word[idx] <= add_sum; carry_reg <= add_cout; idx <= idx + 1.
  - When idx == WORDS-1: go to DONE.
  - No other word of the result is written during RUN.
- DONE:
  - rsp_valid = 1; req_ready = 0.
  - rsp_sum, rsp_carry, rsp_ovf held stable until rsp_valid & rsp_ready, then go to IDLE.
  - A new request is accepted in IDLE only; there is no same-cycle turnaround from DONE.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Latency: the request handshake occurs at edge T; rsp_valid is first high after edge T + WORDS. Throughput is one operation per WORDS + 2 cycles when rsp_ready is held high.
- Arithmetic:
  - rsp_carry = add_cout captured on the last word.
  - rsp_ovf = (A[W-1] == B_eff[W-1]) & (rsp_sum[W-1] != A[W-1]), registered with the final word.
  - All sums are modulo 2^W.
- Boundaries:
  - req_valid deasserted before the handshake: no effect.
  - req_* changing during RUN/DONE: ignored, because the operands are latched.
  - rsp_ready high while rsp_valid is low: ignored.
  - Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; the in-flight result is discarded and no rsp_valid pulse is produced.
  - WORDS = 1: RUN lasts exactly one cycle.
  - idx width = clog2(WORDS) with a minimum of 1; idx never wraps past WORDS-1.

Test Plan (WORDS = 4 unless stated; the bench instantiates FullAdder32bit on the add_* ports):
- Add, all-ones + 1: A = 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B = 1, op = 0 -> rsp_sum = 0, rsp_carry = 1, rsp_ovf = 0; rsp_valid first high 4 edges after the accept edge.
- Subtract with borrow: A = 0, B = 1, op = 1 -> rsp_sum = all ones (0xFFFF…FFFF), rsp_carry = 0, rsp_ovf = 0; add_cin = 1 in the first RUN cycle only.
- Signed overflow: A = 0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B = 1, op = 0 -> rsp_sum = 0x80000000_00000000_00000000_00000000, rsp_carry = 0, rsp_ovf = 1.
- Backpressure: hold rsp_ready low for 5 cycles after rsp_valid rises, with a second req_valid pending -> outputs stable, req_ready = 0, second request not accepted; it is accepted in the IDLE cycle after the response handshake.
- Reset mid-operation: pulse rst_n low while idx = 2 -> all outputs at reset values immediately, no rsp_valid; next request 5 + 3 -> rsp_sum = 8 with correct latency.
- WORDS = 1 build: A = 0x80000000, B = 0x80000000, op = 0 -> rsp_sum = 0, rsp_carry = 1, rsp_ovf = 1; rsp_valid first high 1 edge after the accept edge.
